// File: rtl/spu_issue_scoreboard_pkg.sv
// ============================================================================
// Module      : spu_pkg
// Description : Shared constants, unit ids and issue packet for the SPU
//               issue scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spu_pkg;

    localparam int NUM_REGS = 128;
    localparam int REG_AW   = $clog2(NUM_REGS);
    localparam int LAT_W    = 4;
    localparam int MAX_LAT  = 7;

    localparam logic [2:0] SP_FX  = 3'd1;
    localparam logic [2:0] SP_FP  = 3'd2;
    localparam logic [2:0] BYTE   = 3'd3;
    localparam logic [2:0] PERM   = 3'd4;
    localparam logic [2:0] LS     = 3'd5;
    localparam logic [2:0] BRANCH = 3'd6;

    typedef struct packed {
        logic [31:0]       instr;
        logic [6:0]        id;
        logic [REG_AW-1:0] dst;
        logic [2:0]        unit;
        logic [LAT_W-1:0]  lat;
        logic              reg_wr;
        logic [REG_AW-1:0] ra;
        logic [REG_AW-1:0] rb;
        logic [REG_AW-1:0] rc;
    } issue_pkt_t;

    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        return (lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : lat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/spu_issue_scoreboard_scb_counter_bank.sv
// ============================================================================
// Module      : scb_counter_bank
// Description : Per-register result-latency countdown counters with two set
//               ports and busy/count read ports for both issue slots.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scb_counter_bank
    import spu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_even_en,
    input  logic [REG_AW-1:0]      set_even_dst,
    input  logic [LAT_W-1:0]       set_even_lat,
    input  logic                   set_odd_en,
    input  logic [REG_AW-1:0]      set_odd_dst,
    input  logic [LAT_W-1:0]       set_odd_lat,
    input  logic [2:0][REG_AW-1:0] rd_addr_even,
    input  logic [2:0][REG_AW-1:0] rd_addr_odd,
    output logic [2:0]             rd_busy_even,
    output logic [2:0]             rd_busy_odd,
    input  logic [REG_AW-1:0]      waw_addr_even,
    input  logic [REG_AW-1:0]      waw_addr_odd,
    output logic [LAT_W-1:0]       waw_cnt_even,
    output logic [LAT_W-1:0]       waw_cnt_odd
);

    logic [LAT_W-1:0] cnt_q [NUM_REGS];
    logic [LAT_W-1:0] cnt_d [NUM_REGS];

    // Issue-set overrides the decrement; the two set ports never share a dst.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
        end
        if (set_even_en) begin
            cnt_d[set_even_dst] = set_even_lat;
        end
        if (set_odd_en) begin
            cnt_d[set_odd_dst] = set_odd_lat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    generate
        for (genvar i = 0; i < 3; i++) begin : g_rd
            assign rd_busy_even[i] = (cnt_q[rd_addr_even[i]] != '0);
            assign rd_busy_odd[i]  = (cnt_q[rd_addr_odd[i]]  != '0);
        end
    endgenerate

    assign waw_cnt_even = cnt_q[waw_addr_even];
    assign waw_cnt_odd  = cnt_q[waw_addr_odd];

endmodule

`default_nettype wire

// File: rtl/spu_issue_scoreboard.sv
// ============================================================================
// Module      : spu_issue_scoreboard
// Description : Dual-issue RAW/WAW scoreboard and registered issue stage for
//               the even/odd SPU pipes. Macro SPU_SCB_STATS_EN adds counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spu_issue_scoreboard
    import spu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              even_valid,
    input  logic              odd_valid,
    output logic              even_ready,
    output logic              odd_ready,
    input  logic [31:0]       full_instr_even,
    input  logic [31:0]       full_instr_odd,
    input  logic [6:0]        instr_id_even,
    input  logic [6:0]        instr_id_odd,
    input  logic [REG_AW-1:0] reg_dst_even,
    input  logic [REG_AW-1:0] reg_dst_odd,
    input  logic [2:0]        unit_id_even,
    input  logic [2:0]        unit_id_odd,
    input  logic [LAT_W-1:0]  latency_even,
    input  logic [LAT_W-1:0]  latency_odd,
    input  logic              reg_wr_even,
    input  logic              reg_wr_odd,
    input  logic [REG_AW-1:0] ra_addr_even,
    input  logic [REG_AW-1:0] rb_addr_even,
    input  logic [REG_AW-1:0] rc_addr_even,
    input  logic [REG_AW-1:0] ra_addr_odd,
    input  logic [REG_AW-1:0] rb_addr_odd,
    input  logic [REG_AW-1:0] rc_addr_odd,
    input  logic              ra_use_even,
    input  logic              rb_use_even,
    input  logic              rc_use_even,
    input  logic              ra_use_odd,
    input  logic              rb_use_odd,
    input  logic              rc_use_odd,
    output logic              iss_valid_even,
    output logic [31:0]       iss_full_instr_even,
    output logic [6:0]        iss_instr_id_even,
    output logic [REG_AW-1:0] iss_reg_dst_even,
    output logic [2:0]        iss_unit_id_even,
    output logic [LAT_W-1:0]  iss_latency_even,
    output logic              iss_reg_wr_even,
    output logic [REG_AW-1:0] iss_ra_addr_even,
    output logic [REG_AW-1:0] iss_rb_addr_even,
    output logic [REG_AW-1:0] iss_rc_addr_even,
    output logic              iss_valid_odd,
    output logic [31:0]       iss_full_instr_odd,
    output logic [6:0]        iss_instr_id_odd,
    output logic [REG_AW-1:0] iss_reg_dst_odd,
    output logic [2:0]        iss_unit_id_odd,
    output logic [LAT_W-1:0]  iss_latency_odd,
    output logic              iss_reg_wr_odd,
    output logic [REG_AW-1:0] iss_ra_addr_odd,
    output logic [REG_AW-1:0] iss_rb_addr_odd,
    output logic [REG_AW-1:0] iss_rc_addr_odd,
`ifdef SPU_SCB_STATS_EN
    output logic [31:0]       stall_cnt_even,
    output logic [31:0]       stall_cnt_odd,
    output logic [31:0]       issue_cnt,
`endif
    output logic              stall_even,
    output logic              stall_odd
);

    issue_pkt_t       pkt_even;
    issue_pkt_t       pkt_odd;
    issue_pkt_t       iss_even_q;
    issue_pkt_t       iss_odd_q;
    logic             iss_valid_even_q;
    logic             iss_valid_odd_q;
    logic             stall_even_q;
    logic             stall_odd_q;

    logic [2:0]       use_even;
    logic [2:0]       use_odd;
    logic [2:0]       busy_even;
    logic [2:0]       busy_odd;
    logic [2:0]       dep_on_even;
    logic [LAT_W-1:0] waw_cnt_even;
    logic [LAT_W-1:0] waw_cnt_odd;
    logic             hazard_even;
    logic             hazard_odd;
    logic             order_block;
    logic             intra_block;

    assign pkt_even = '{instr: full_instr_even, id: instr_id_even, dst: reg_dst_even,
                        unit: unit_id_even, lat: latency_even, reg_wr: reg_wr_even,
                        ra: ra_addr_even, rb: rb_addr_even, rc: rc_addr_even};
    assign pkt_odd  = '{instr: full_instr_odd, id: instr_id_odd, dst: reg_dst_odd,
                        unit: unit_id_odd, lat: latency_odd, reg_wr: reg_wr_odd,
                        ra: ra_addr_odd, rb: rb_addr_odd, rc: rc_addr_odd};

    assign use_even = {rc_use_even, rb_use_even, ra_use_even};
    assign use_odd  = {rc_use_odd, rb_use_odd, ra_use_odd};

    scb_counter_bank u_bank (
        .clk           (clk),
        .rst           (rst),
        .set_even_en   (even_ready & reg_wr_even & (latency_even != '0)),
        .set_even_dst  (reg_dst_even),
        .set_even_lat  (clamp_lat(latency_even)),
        .set_odd_en    (odd_ready & reg_wr_odd & (latency_odd != '0)),
        .set_odd_dst   (reg_dst_odd),
        .set_odd_lat   (clamp_lat(latency_odd)),
        .rd_addr_even  ({rc_addr_even, rb_addr_even, ra_addr_even}),
        .rd_addr_odd   ({rc_addr_odd, rb_addr_odd, ra_addr_odd}),
        .rd_busy_even  (busy_even),
        .rd_busy_odd   (busy_odd),
        .waw_addr_even (reg_dst_even),
        .waw_addr_odd  (reg_dst_odd),
        .waw_cnt_even  (waw_cnt_even),
        .waw_cnt_odd   (waw_cnt_odd)
    );

    assign hazard_even = (|(use_even & busy_even)) |
                         (reg_wr_even & (waw_cnt_even > latency_even));
    assign hazard_odd  = (|(use_odd & busy_odd)) |
                         (reg_wr_odd & (waw_cnt_odd > latency_odd));

    // Odd is the younger slot: it may never overtake a blocked even, and it
    // cannot consume or overwrite the even result issued alongside it.
    assign dep_on_even = {rc_addr_odd == reg_dst_even,
                          rb_addr_odd == reg_dst_even,
                          ra_addr_odd == reg_dst_even};
    assign order_block = even_valid & ~even_ready;
    assign intra_block = even_ready & reg_wr_even &
                         ((|(use_odd & dep_on_even)) |
                          (reg_wr_odd & (reg_dst_odd == reg_dst_even)));

    assign even_ready = rst & even_valid & ~hazard_even;
    assign odd_ready  = rst & odd_valid & ~hazard_odd & ~order_block & ~intra_block;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iss_even_q       <= '0;
            iss_odd_q        <= '0;
            iss_valid_even_q <= 1'b0;
            iss_valid_odd_q  <= 1'b0;
            stall_even_q     <= 1'b0;
            stall_odd_q      <= 1'b0;
        end else begin
            iss_valid_even_q <= even_ready;
            iss_valid_odd_q  <= odd_ready;
            stall_even_q     <= even_valid & ~even_ready;
            stall_odd_q      <= odd_valid & ~odd_ready;
            if (even_ready) begin
                iss_even_q <= pkt_even;
            end
            if (odd_ready) begin
                iss_odd_q <= pkt_odd;
            end
        end
    end

    assign iss_valid_even      = iss_valid_even_q;
    assign iss_full_instr_even = iss_even_q.instr;
    assign iss_instr_id_even   = iss_even_q.id;
    assign iss_reg_dst_even    = iss_even_q.dst;
    assign iss_unit_id_even    = iss_even_q.unit;
    assign iss_latency_even    = iss_even_q.lat;
    assign iss_reg_wr_even     = iss_even_q.reg_wr;
    assign iss_ra_addr_even    = iss_even_q.ra;
    assign iss_rb_addr_even    = iss_even_q.rb;
    assign iss_rc_addr_even    = iss_even_q.rc;

    assign iss_valid_odd       = iss_valid_odd_q;
    assign iss_full_instr_odd  = iss_odd_q.instr;
    assign iss_instr_id_odd    = iss_odd_q.id;
    assign iss_reg_dst_odd     = iss_odd_q.dst;
    assign iss_unit_id_odd     = iss_odd_q.unit;
    assign iss_latency_odd     = iss_odd_q.lat;
    assign iss_reg_wr_odd      = iss_odd_q.reg_wr;
    assign iss_ra_addr_odd     = iss_odd_q.ra;
    assign iss_rb_addr_odd     = iss_odd_q.rb;
    assign iss_rc_addr_odd     = iss_odd_q.rc;

    assign stall_even = stall_even_q;
    assign stall_odd  = stall_odd_q;

`ifdef SPU_SCB_STATS_EN
    logic [31:0] stall_cnt_even_q;
    logic [31:0] stall_cnt_odd_q;
    logic [31:0] issue_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_even_q <= '0;
            stall_cnt_odd_q  <= '0;
            issue_cnt_q      <= '0;
        end else begin
            stall_cnt_even_q <= stall_cnt_even_q + 32'(even_valid & ~even_ready);
            stall_cnt_odd_q  <= stall_cnt_odd_q + 32'(odd_valid & ~odd_ready);
            issue_cnt_q      <= issue_cnt_q + 32'(even_ready) + 32'(odd_ready);
        end
    end

    assign stall_cnt_even = stall_cnt_even_q;
    assign stall_cnt_odd  = stall_cnt_odd_q;
    assign issue_cnt      = issue_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spu_issue_scoreboard.sv
// ============================================================================
// Module      : tb_spu_issue_scoreboard
// Description : Self-checking bench for spu_issue_scoreboard against a
//               ready-time reference model. Honors SPU_SCB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spu_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        even_valid, odd_valid, even_ready, odd_ready;
    logic [31:0] full_instr_even, full_instr_odd;
    logic [6:0]  instr_id_even, instr_id_odd, reg_dst_even, reg_dst_odd;
    logic [2:0]  unit_id_even, unit_id_odd;
    logic [3:0]  latency_even, latency_odd;
    logic        reg_wr_even, reg_wr_odd;
    logic [6:0]  ra_addr_even, rb_addr_even, rc_addr_even;
    logic [6:0]  ra_addr_odd, rb_addr_odd, rc_addr_odd;
    logic        ra_use_even, rb_use_even, rc_use_even;
    logic        ra_use_odd, rb_use_odd, rc_use_odd;
    logic        iss_valid_even, iss_valid_odd;
    logic [31:0] iss_full_instr_even, iss_full_instr_odd;
    logic [6:0]  iss_instr_id_even, iss_instr_id_odd, iss_reg_dst_even, iss_reg_dst_odd;
    logic [2:0]  iss_unit_id_even, iss_unit_id_odd;
    logic [3:0]  iss_latency_even, iss_latency_odd;
    logic        iss_reg_wr_even, iss_reg_wr_odd;
    logic [6:0]  iss_ra_addr_even, iss_rb_addr_even, iss_rc_addr_even;
    logic [6:0]  iss_ra_addr_odd, iss_rb_addr_odd, iss_rc_addr_odd;
    logic        stall_even, stall_odd;
`ifdef SPU_SCB_STATS_EN
    logic [31:0] stall_cnt_even, stall_cnt_odd, issue_cnt;
    logic [31:0] m_stall_e, m_stall_o, m_issue;
`endif

    spu_issue_scoreboard dut (
        .clk(clk), .rst(rst),
        .even_valid(even_valid), .odd_valid(odd_valid),
        .even_ready(even_ready), .odd_ready(odd_ready),
        .full_instr_even(full_instr_even), .full_instr_odd(full_instr_odd),
        .instr_id_even(instr_id_even), .instr_id_odd(instr_id_odd),
        .reg_dst_even(reg_dst_even), .reg_dst_odd(reg_dst_odd),
        .unit_id_even(unit_id_even), .unit_id_odd(unit_id_odd),
        .latency_even(latency_even), .latency_odd(latency_odd),
        .reg_wr_even(reg_wr_even), .reg_wr_odd(reg_wr_odd),
        .ra_addr_even(ra_addr_even), .rb_addr_even(rb_addr_even), .rc_addr_even(rc_addr_even),
        .ra_addr_odd(ra_addr_odd), .rb_addr_odd(rb_addr_odd), .rc_addr_odd(rc_addr_odd),
        .ra_use_even(ra_use_even), .rb_use_even(rb_use_even), .rc_use_even(rc_use_even),
        .ra_use_odd(ra_use_odd), .rb_use_odd(rb_use_odd), .rc_use_odd(rc_use_odd),
        .iss_valid_even(iss_valid_even), .iss_full_instr_even(iss_full_instr_even),
        .iss_instr_id_even(iss_instr_id_even), .iss_reg_dst_even(iss_reg_dst_even),
        .iss_unit_id_even(iss_unit_id_even), .iss_latency_even(iss_latency_even),
        .iss_reg_wr_even(iss_reg_wr_even), .iss_ra_addr_even(iss_ra_addr_even),
        .iss_rb_addr_even(iss_rb_addr_even), .iss_rc_addr_even(iss_rc_addr_even),
        .iss_valid_odd(iss_valid_odd), .iss_full_instr_odd(iss_full_instr_odd),
        .iss_instr_id_odd(iss_instr_id_odd), .iss_reg_dst_odd(iss_reg_dst_odd),
        .iss_unit_id_odd(iss_unit_id_odd), .iss_latency_odd(iss_latency_odd),
        .iss_reg_wr_odd(iss_reg_wr_odd), .iss_ra_addr_odd(iss_ra_addr_odd),
        .iss_rb_addr_odd(iss_rb_addr_odd), .iss_rc_addr_odd(iss_rc_addr_odd),
`ifdef SPU_SCB_STATS_EN
        .stall_cnt_even(stall_cnt_even), .stall_cnt_odd(stall_cnt_odd), .issue_cnt(issue_cnt),
`endif
        .stall_even(stall_even), .stall_odd(stall_odd)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned cyc;
    int unsigned rdy_at [128];
    logic [63:0] exp_fld_e, exp_fld_o;
    logic [20:0] exp_src_e, exp_src_o;
    bit          exp_iv_e, exp_iv_o, exp_st_e, exp_st_o;
    bit          acc_e, acc_o, dut_er, dut_or;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Remaining busy cycles of a register, from the cycle at which it frees up.
    function automatic int cnt_of(input logic [6:0] r);
        return (rdy_at[r] > cyc) ? int'(rdy_at[r] - cyc) : 0;
    endfunction

    function automatic int lat_clamp(input logic [3:0] l);
        return (int'(l) > 7) ? 7 : int'(l);
    endfunction

    task automatic model_ready(output bit er, output bit orr);
        bit hz_e, hz_o;
        hz_e = (ra_use_even && cnt_of(ra_addr_even) != 0) ||
               (rb_use_even && cnt_of(rb_addr_even) != 0) ||
               (rc_use_even && cnt_of(rc_addr_even) != 0) ||
               (reg_wr_even && cnt_of(reg_dst_even) > int'(latency_even));
        er = even_valid && !hz_e;
        hz_o = (ra_use_odd && cnt_of(ra_addr_odd) != 0) ||
               (rb_use_odd && cnt_of(rb_addr_odd) != 0) ||
               (rc_use_odd && cnt_of(rc_addr_odd) != 0) ||
               (reg_wr_odd && cnt_of(reg_dst_odd) > int'(latency_odd)) ||
               (even_valid && !er) ||
               (er && reg_wr_even && ((ra_use_odd && ra_addr_odd == reg_dst_even) ||
                                      (rb_use_odd && rb_addr_odd == reg_dst_even) ||
                                      (rc_use_odd && rc_addr_odd == reg_dst_even) ||
                                      (reg_wr_odd && reg_dst_odd == reg_dst_even)));
        orr = odd_valid && !hz_o;
    endtask

    task automatic clear_model();
        foreach (rdy_at[i]) rdy_at[i] = 0;
        cyc = 0;
        exp_fld_e = '0; exp_fld_o = '0; exp_src_e = '0; exp_src_o = '0;
        exp_iv_e = 0; exp_iv_o = 0; exp_st_e = 0; exp_st_o = 0;
`ifdef SPU_SCB_STATS_EN
        m_stall_e = '0; m_stall_o = '0; m_issue = '0;
`endif
    endtask

    // Entered just after a falling edge with inputs applied; returns at the next one.
    task automatic run_cycle();
        #1;
        model_ready(acc_e, acc_o);
        dut_er = even_ready;
        dut_or = odd_ready;
        check_eq("even_ready", {63'd0, even_ready}, {63'd0, acc_e});
        check_eq("odd_ready", {63'd0, odd_ready}, {63'd0, acc_o});
        exp_iv_e = acc_e;
        exp_iv_o = acc_o;
        exp_st_e = even_valid && !acc_e;
        exp_st_o = odd_valid && !acc_o;
        if (acc_e) begin
            exp_fld_e = {10'd0, full_instr_even, instr_id_even, reg_dst_even, unit_id_even,
                         latency_even, reg_wr_even};
            exp_src_e = {ra_addr_even, rb_addr_even, rc_addr_even};
            if (reg_wr_even && latency_even != 0)
                rdy_at[reg_dst_even] = cyc + 1 + lat_clamp(latency_even);
        end
        if (acc_o) begin
            exp_fld_o = {10'd0, full_instr_odd, instr_id_odd, reg_dst_odd, unit_id_odd,
                         latency_odd, reg_wr_odd};
            exp_src_o = {ra_addr_odd, rb_addr_odd, rc_addr_odd};
            if (reg_wr_odd && latency_odd != 0)
                rdy_at[reg_dst_odd] = cyc + 1 + lat_clamp(latency_odd);
        end
`ifdef SPU_SCB_STATS_EN
        m_stall_e += 32'(exp_st_e);
        m_stall_o += 32'(exp_st_o);
        m_issue   += 32'(acc_e) + 32'(acc_o);
`endif
        @(posedge clk);
        #1;
        cyc++;
        check_eq("iss_valid_even", {63'd0, iss_valid_even}, {63'd0, exp_iv_e});
        check_eq("iss_valid_odd", {63'd0, iss_valid_odd}, {63'd0, exp_iv_o});
        check_eq("stall_even", {63'd0, stall_even}, {63'd0, exp_st_e});
        check_eq("stall_odd", {63'd0, stall_odd}, {63'd0, exp_st_o});
        check_eq("iss_fields_even", {10'd0, iss_full_instr_even, iss_instr_id_even, iss_reg_dst_even,
                 iss_unit_id_even, iss_latency_even, iss_reg_wr_even}, exp_fld_e);
        check_eq("iss_fields_odd", {10'd0, iss_full_instr_odd, iss_instr_id_odd, iss_reg_dst_odd,
                 iss_unit_id_odd, iss_latency_odd, iss_reg_wr_odd}, exp_fld_o);
        check_eq("iss_src_even", {43'd0, iss_ra_addr_even, iss_rb_addr_even, iss_rc_addr_even},
                 {43'd0, exp_src_e});
        check_eq("iss_src_odd", {43'd0, iss_ra_addr_odd, iss_rb_addr_odd, iss_rc_addr_odd},
                 {43'd0, exp_src_o});
`ifdef SPU_SCB_STATS_EN
        check_eq("stall_cnt_even", {32'd0, stall_cnt_even}, {32'd0, m_stall_e});
        check_eq("stall_cnt_odd", {32'd0, stall_cnt_odd}, {32'd0, m_stall_o});
        check_eq("issue_cnt", {32'd0, issue_cnt}, {32'd0, m_issue});
`endif
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_iss_valid"}, {62'd0, iss_valid_even, iss_valid_odd}, 64'd0);
        check_eq({tag, "_stall"}, {62'd0, stall_even, stall_odd}, 64'd0);
        check_eq({tag, "_ready"}, {62'd0, even_ready, odd_ready}, 64'd0);
        check_eq({tag, "_fields"}, {10'd0, iss_full_instr_even, iss_instr_id_even, iss_reg_dst_even,
                 iss_unit_id_even, iss_latency_even, iss_reg_wr_even}, 64'd0);
    endtask

    // Reset is asserted part-way through the low phase, well clear of any edge.
    task automatic async_reset();
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_even(input bit v, input int dst, input int lat, input bit wr,
                            input int ra, input bit rau, input int rb, input bit rbu);
        even_valid = v; full_instr_even = $urandom; instr_id_even = 7'($urandom_range(0, 127));
        reg_dst_even = 7'(dst); unit_id_even = 3'($urandom_range(1, 6));
        latency_even = 4'(lat); reg_wr_even = wr;
        ra_addr_even = 7'(ra); ra_use_even = rau; rb_addr_even = 7'(rb); rb_use_even = rbu;
        rc_addr_even = 7'd0; rc_use_even = 1'b0;
    endtask

    task automatic set_odd(input bit v, input int dst, input int lat, input bit wr,
                           input int ra, input bit rau, input int rb, input bit rbu);
        odd_valid = v; full_instr_odd = $urandom; instr_id_odd = 7'($urandom_range(0, 127));
        reg_dst_odd = 7'(dst); unit_id_odd = 3'($urandom_range(1, 6));
        latency_odd = 4'(lat); reg_wr_odd = wr;
        ra_addr_odd = 7'(ra); ra_use_odd = rau; rb_addr_odd = 7'(rb); rb_use_odd = rbu;
        rc_addr_odd = 7'd0; rc_use_odd = 1'b0;
    endtask

    task automatic rand_even();
        set_even($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 15),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9), 1'($urandom),
                 $urandom_range(0, 9), 1'($urandom));
        rc_addr_even = 7'($urandom_range(0, 9)); rc_use_even = 1'($urandom);
    endtask

    task automatic rand_odd();
        set_odd($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 15),
                $urandom_range(0, 3) != 0, $urandom_range(0, 9), 1'($urandom),
                $urandom_range(0, 9), 1'($urandom));
        rc_addr_odd = 7'($urandom_range(0, 9)); rc_use_odd = 1'($urandom);
    endtask

    task automatic idle(input int n);
        even_valid = 1'b0;
        odd_valid  = 1'b0;
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        int stalls;
        rst = 1'b0;
        clear_model();
        set_even(1, 1, 2, 1, 0, 0, 0, 0);
        set_odd(1, 3, 2, 1, 0, 0, 0, 0);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Independent pair issues together.
        set_even(1, 2, 3, 1, 10, 1, 11, 1);
        set_odd(1, 5, 4, 1, 10, 1, 11, 1);
        run_cycle();
        check_eq("pair_ready", {62'd0, dut_er, dut_or}, 64'd3);
        idle(8);

        // RAW: reader arriving two cycles after the writer issues waits two cycles.
        set_even(1, 2, 3, 1, 20, 0, 21, 0);
        run_cycle();
        idle(1);
        set_even(1, 30, 1, 0, 2, 1, 21, 0);
        stalls = 0;
        for (int i = 0; i < 10 && !dut_er; i++) begin
            run_cycle();
            if (!dut_er) stalls++;
        end
        check_eq("raw_stalls", 64'(stalls), 64'd2);
        idle(8);

        // Intra-pair dependence: odd waits behind the even result.
        set_even(1, 7, 2, 1, 20, 0, 21, 0);
        set_odd(1, 40, 1, 0, 7, 1, 21, 0);
        run_cycle();
        check_eq("intra_ready", {62'd0, dut_er, dut_or}, 64'd2);
        even_valid = 1'b0;
        stalls = 0;
        for (int i = 0; i < 10 && !dut_or; i++) begin
            run_cycle();
            if (!dut_or) stalls++;
        end
        check_eq("intra_stalls", 64'(stalls), 64'd2);
        idle(8);

        // Program order: blocked even holds back an independent odd.
        set_even(1, 3, 3, 1, 20, 0, 21, 0);
        run_cycle();
        idle(1);
        set_even(1, 50, 1, 1, 3, 1, 21, 0);
        set_odd(1, 51, 1, 1, 22, 1, 23, 0);
        run_cycle();
        check_eq("order_block", {62'd0, dut_er, dut_or}, 64'd0);
        for (int i = 0; i < 10 && !dut_er; i++) run_cycle();
        check_eq("order_release", {62'd0, dut_er, dut_or}, 64'd3);
        idle(8);

        // WAW: equal latency passes immediately, shorter latency waits.
        set_even(1, 9, 6, 1, 20, 0, 21, 0);
        run_cycle();
        set_even(1, 9, 6, 1, 20, 0, 21, 0);
        run_cycle();
        check_eq("waw_equal_lat", {63'd0, dut_er}, 64'd1);
        set_even(1, 9, 2, 1, 20, 0, 21, 0);
        stalls = 0;
        for (int i = 0; i < 12 && (stalls == 0 || !dut_er); i++) begin
            run_cycle();
            if (dut_er) break;
            stalls++;
        end
        check_eq("waw_stalls", 64'(stalls), 64'd4);
        idle(8);

        // Async reset forgets in-flight writes.
        set_even(1, 4, 5, 1, 20, 0, 21, 0);
        run_cycle();
        idle(1);
        async_reset();
        set_even(1, 60, 1, 0, 4, 1, 21, 0);
        run_cycle();
        check_eq("post_reset_issue", {63'd0, dut_er}, 64'd1);
        idle(2);

        // Randomized traffic; unaccepted slots are held stable.
        rand_even();
        rand_odd();
        for (int n = 0; n < 1500; n++) begin
            run_cycle();
            if (n == 700) begin
                async_reset();
                rand_even();
                rand_odd();
            end else begin
                if (!even_valid || acc_e) rand_even();
                if (!odd_valid || acc_o) rand_odd();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
